// File: rtl/pipeline_ctrl.sv
// Hazard and stall scheduler for the 5-stage pipeline: load-use bubbles, branch
// flushes, and whole-pipe freezes while UART transfers or multi-cycle FPU ops sit in EX.
module pipeline_ctrl #(
    parameter int FPU_LATENCY     = 3,
    parameter int STALL_CNT_WIDTH = 16
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [4:0]                 id_rs,
    input  logic [4:0]                 id_rt,
    input  logic                       id_uses_rt,
    input  logic                       ex_MemRead,
    input  logic [4:0]                 ex_dst,
    input  logic                       ex_UARTtoReg,
    input  logic                       ex_RegtoUART,
    input  logic                       ex_fpu_start,
    input  logic                       branch_taken,
    input  logic                       uart_rx_valid,
    input  logic                       uart_tx_ready,
    output logic                       pc_enable,
    output logic                       inst_enable,
    output logic                       id_ex_bubble,
    output logic                       flush_if_id,
    output logic                       ex_hold,
    output logic                       uart_rx_ack,
    output logic                       uart_tx_valid,
    output logic [1:0]                 state,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        UART_WAIT = 2'd1,
        FPU_WAIT  = 2'd2
    } state_t;

    localparam bit         FPU_MULTI     = (FPU_LATENCY > 1);
    localparam logic [3:0] FPU_HOLD_INIT = 4'(FPU_LATENCY - 1);

    state_t                     state_reg, state_next;
    logic [3:0]                 cnt_reg, cnt_next;
    logic                       wait_rx_reg, wait_rx_next;
    logic [STALL_CNT_WIDTH-1:0] stall_reg;

    logic rx_block, tx_block, load_use;

    // $0 is hardwired, so a load targeting it can never create a hazard.
    assign load_use = ex_MemRead && (ex_dst != 5'd0) &&
                      ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));
    assign rx_block = ex_UARTtoReg && !uart_rx_valid;
    assign tx_block = ex_RegtoUART && !uart_tx_ready;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_reg   <= RUN;
            cnt_reg     <= 4'd0;
            wait_rx_reg <= 1'b0;
            stall_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            wait_rx_reg <= wait_rx_next;
            if (!pc_enable && (stall_reg != '1))
                stall_reg <= stall_reg + 1'b1;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        wait_rx_next  = wait_rx_reg;
        pc_enable     = 1'b1;
        inst_enable   = 1'b1;
        id_ex_bubble  = 1'b0;
        flush_if_id   = 1'b0;
        ex_hold       = 1'b0;
        uart_rx_ack   = 1'b0;
        uart_tx_valid = 1'b0;

        case (state_reg)
            RUN: begin
                if (rx_block || tx_block) begin
                    ex_hold      = 1'b1;
                    pc_enable    = 1'b0;
                    inst_enable  = 1'b0;
                    wait_rx_next = rx_block;
                    state_next   = UART_WAIT;
                end else begin
                    // Not blocked, so any requested transfer has a ready peer.
                    uart_rx_ack   = ex_UARTtoReg;
                    uart_tx_valid = ex_RegtoUART;
                    if (FPU_MULTI && ex_fpu_start) begin
                        ex_hold     = 1'b1;
                        pc_enable   = 1'b0;
                        inst_enable = 1'b0;
                        cnt_next    = FPU_HOLD_INIT;
                        state_next  = FPU_WAIT;
                    end else if (branch_taken) begin
                        flush_if_id  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_enable    = 1'b0;
                        inst_enable  = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                end
            end
            UART_WAIT: begin
                if (wait_rx_reg ? uart_rx_valid : uart_tx_ready) begin
                    uart_rx_ack   = wait_rx_reg;
                    uart_tx_valid = !wait_rx_reg;
                    state_next    = RUN;
                end else begin
                    ex_hold     = 1'b1;
                    pc_enable   = 1'b0;
                    inst_enable = 1'b0;
                end
            end
            FPU_WAIT: begin
                if (cnt_reg > 4'd1) begin
                    ex_hold     = 1'b1;
                    pc_enable   = 1'b0;
                    inst_enable = 1'b0;
                    cnt_next    = cnt_reg - 4'd1;
                end else begin
                    cnt_next   = 4'd0;
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase

        // Reset squashes the front end and suppresses any pending handshake.
        if (reset) begin
            pc_enable     = 1'b0;
            inst_enable   = 1'b0;
            id_ex_bubble  = 1'b1;
            flush_if_id   = 1'b1;
            ex_hold       = 1'b0;
            uart_rx_ack   = 1'b0;
            uart_tx_valid = 1'b0;
        end
    end

    assign state        = state_reg;
    assign stall_cycles = stall_reg;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, directed multi-cycle sequences and a
// randomized run, all checked against a cycle-level behavioural model.
module tb_pipeline_ctrl;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       reset;
    logic [4:0] id_rs, id_rt, ex_dst;
    logic       id_uses_rt, ex_MemRead, ex_UARTtoReg, ex_RegtoUART;
    logic       ex_fpu_start, branch_taken, uart_rx_valid, uart_tx_ready;

    logic        pe_a, ie_a, bub_a, fl_a, hold_a, ack_a, txv_a;
    logic [1:0]  state_a;
    logic [15:0] stall_a;
    logic        pe_b, ie_b, bub_b, fl_b, hold_b, ack_b, txv_b;
    logic [1:0]  state_b;
    logic [2:0]  stall_b;

    pipeline_ctrl #(.FPU_LATENCY(3), .STALL_CNT_WIDTH(16)) dut_a (
        .CLK(CLK), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_dst(ex_dst), .ex_UARTtoReg(ex_UARTtoReg),
        .ex_RegtoUART(ex_RegtoUART), .ex_fpu_start(ex_fpu_start), .branch_taken(branch_taken),
        .uart_rx_valid(uart_rx_valid), .uart_tx_ready(uart_tx_ready),
        .pc_enable(pe_a), .inst_enable(ie_a), .id_ex_bubble(bub_a), .flush_if_id(fl_a),
        .ex_hold(hold_a), .uart_rx_ack(ack_a), .uart_tx_valid(txv_a),
        .state(state_a), .stall_cycles(stall_a));

    pipeline_ctrl #(.FPU_LATENCY(1), .STALL_CNT_WIDTH(3)) dut_b (
        .CLK(CLK), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_MemRead(ex_MemRead), .ex_dst(ex_dst), .ex_UARTtoReg(ex_UARTtoReg),
        .ex_RegtoUART(ex_RegtoUART), .ex_fpu_start(ex_fpu_start), .branch_taken(branch_taken),
        .uart_rx_valid(uart_rx_valid), .uart_tx_ready(uart_tx_ready),
        .pc_enable(pe_b), .inst_enable(ie_b), .id_ex_bubble(bub_b), .flush_if_id(fl_b),
        .ex_hold(hold_b), .uart_rx_ack(ack_b), .uart_tx_valid(txv_b),
        .state(state_b), .stall_cycles(stall_b));

    // Output bundle order: {pc_enable, inst_enable, id_ex_bubble, flush_if_id, ex_hold, rx_ack, tx_valid}
    logic [6:0] obs_a, obs_b;
    assign obs_a = {pe_a, ie_a, bub_a, fl_a, hold_a, ack_a, txv_a};
    assign obs_b = {pe_b, ie_b, bub_b, fl_b, hold_b, ack_b, txv_b};

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Model: uart_dir 0=none 1=awaiting rx 2=awaiting tx; fpu_left = cycles still to spend in the FPU wait.
    typedef struct {
        int uart_dir;
        int fpu_left;
        int stalls;
    } mdl_t;

    mdl_t ma, mb;
    bit   model_valid = 1'b0;

    logic [6:0] obs_seen, obs_b_seen;
    logic [1:0] state_seen;
    int         stall_seen, stall_b_seen;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic void model_eval(input mdl_t m, input int lat, input int smax,
                                       output logic [6:0] outs, output int st, output mdl_t nm);
        logic pe, ie, bub, fl, hold, ack, txv;
        logic rx_need, tx_need, hazard;
        nm = m;
        st = (m.uart_dir != 0) ? 1 : ((m.fpu_left > 0) ? 2 : 0);
        {pe, ie, bub, fl, hold, ack, txv} = 7'b1100000;
        if (reset) begin
            {pe, ie, bub, fl, hold, ack, txv} = 7'b0011000;
            nm.uart_dir = 0;
            nm.fpu_left = 0;
            nm.stalls   = 0;
        end else begin
            if (m.uart_dir != 0) begin
                if ((m.uart_dir == 1) ? uart_rx_valid : uart_tx_ready) begin
                    ack = (m.uart_dir == 1);
                    txv = (m.uart_dir == 2);
                    nm.uart_dir = 0;
                end else begin
                    {pe, ie, hold} = 3'b001;
                end
            end else if (m.fpu_left > 0) begin
                if (m.fpu_left > 1) {pe, ie, hold} = 3'b001;
                nm.fpu_left = m.fpu_left - 1;
            end else begin
                rx_need = ex_UARTtoReg && !uart_rx_valid;
                tx_need = ex_RegtoUART && !uart_tx_ready;
                hazard  = ex_MemRead && ex_dst != 0 &&
                          (ex_dst == id_rs || (id_uses_rt && ex_dst == id_rt));
                if (rx_need || tx_need) begin
                    {pe, ie, hold} = 3'b001;
                    nm.uart_dir = rx_need ? 1 : 2;
                end else begin
                    ack = ex_UARTtoReg;
                    txv = ex_RegtoUART;
                    if (ex_fpu_start && lat > 1) begin
                        {pe, ie, hold} = 3'b001;
                        nm.fpu_left = lat - 1;
                    end else if (branch_taken) begin
                        {fl, bub} = 2'b11;
                    end else if (hazard) begin
                        {pe, ie, bub} = 3'b001;
                    end
                end
            end
            if (!pe && m.stalls < smax) nm.stalls = m.stalls + 1;
        end
        outs = {pe, ie, bub, fl, hold, ack, txv};
    endfunction

    task automatic cycle();
        logic [6:0] ea, eb;
        int         sa, sb;
        mdl_t       na, nb;
        @(negedge CLK);
        obs_seen     = obs_a;
        obs_b_seen   = obs_b;
        state_seen   = state_a;
        stall_seen   = int'(stall_a);
        stall_b_seen = int'(stall_b);
        model_eval(ma, 3, 65535, ea, sa, na);
        model_eval(mb, 1, 7, eb, sb, nb);
        chk("outs_a", {25'b0, obs_a}, {25'b0, ea});
        chk("outs_b", {25'b0, obs_b}, {25'b0, eb});
        if (model_valid) begin
            chk("state_a", {30'b0, state_a}, sa);
            chk("state_b", {30'b0, state_b}, sb);
            chk("stall_a", {16'b0, stall_a}, ma.stalls);
            chk("stall_b", {29'b0, stall_b}, mb.stalls);
        end
        @(posedge CLK);
        ma = na;
        mb = nb;
        if (reset) model_valid = 1'b1;
        cyc++;
        #1;
    endtask

    task automatic idle();
        reset = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_MemRead = 0; ex_dst = 0;
        ex_UARTtoReg = 0; ex_RegtoUART = 0; ex_fpu_start = 0; branch_taken = 0;
        uart_rx_valid = 0; uart_tx_ready = 0;
    endtask

    typedef struct {
        logic [4:0] rs, rt, dst;
        logic       uses_rt, mr, u2r, r2u, br, rxv, txr;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[11];
    int   base;

    initial begin
        ma = '{0, 0, 0};
        mb = '{0, 0, 0};
        idle();
        reset = 1;

        // Reset held two cycles, then released.
        cycle(); chk("rst_outs0", {25'b0, obs_seen}, 32'b0011000);
        cycle(); chk("rst_outs1", {25'b0, obs_seen}, 32'b0011000);
        chk("rst_stall", stall_seen, 0);
        reset = 0;
        cycle(); chk("post_rst_outs", {25'b0, obs_seen}, 32'b1100000);
        chk("post_rst_state", {30'b0, state_seen}, 0);

        //            rs  rt dst uses mr u2r r2u br rxv txr  exp
        vecs[0]  = '{0,  0,  0,  0,  0, 0,  0,  0, 0,  0,  7'b1100000};
        vecs[1]  = '{5,  0,  5,  0,  1, 0,  0,  0, 0,  0,  7'b0010000};
        vecs[2]  = '{1,  7,  7,  1,  1, 0,  0,  0, 0,  0,  7'b0010000};
        vecs[3]  = '{1,  7,  7,  0,  1, 0,  0,  0, 0,  0,  7'b1100000};
        vecs[4]  = '{0,  0,  0,  1,  1, 0,  0,  0, 0,  0,  7'b1100000};
        vecs[5]  = '{9,  0,  9,  0,  0, 0,  0,  0, 0,  0,  7'b1100000};
        vecs[6]  = '{0,  0,  0,  0,  0, 0,  0,  1, 0,  0,  7'b1111000};
        vecs[7]  = '{5,  0,  5,  0,  1, 0,  0,  1, 0,  0,  7'b1111000};
        vecs[8]  = '{0,  0,  0,  0,  0, 1,  0,  0, 1,  0,  7'b1100010};
        vecs[9]  = '{0,  0,  0,  0,  0, 0,  1,  0, 0,  1,  7'b1100001};
        vecs[10] = '{3,  0,  3,  0,  1, 0,  1,  0, 0,  1,  7'b0010001};
        for (int i = 0; i < 11; i++) begin
            idle();
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_dst = vecs[i].dst;
            id_uses_rt = vecs[i].uses_rt; ex_MemRead = vecs[i].mr;
            ex_UARTtoReg = vecs[i].u2r; ex_RegtoUART = vecs[i].r2u;
            branch_taken = vecs[i].br; uart_rx_valid = vecs[i].rxv; uart_tx_ready = vecs[i].txr;
            cycle();
            chk($sformatf("vec%0d", i), {25'b0, obs_seen}, {25'b0, vecs[i].exp});
            $display("vec %0d outs=%b", i, obs_seen);
        end

        // Single load-use bubble adds exactly one stall cycle; branch adds none.
        idle(); cycle(); base = stall_seen;
        ex_MemRead = 1; ex_dst = 5; id_rs = 5; cycle();
        idle(); branch_taken = 1; ex_MemRead = 1; ex_dst = 5; id_rs = 5; cycle();
        idle(); cycle(); chk("loaduse_stall", stall_seen, base + 1);

        // UART rx wait: four held cycles, then ack pulse and back to RUN.
        base = stall_seen;
        ex_UARTtoReg = 1;
        for (int i = 0; i < 4; i++) begin
            cycle(); chk("uart_hold", {31'b0, obs_seen[2]}, 1);
        end
        uart_rx_valid = 1; cycle();
        chk("uart_release", {25'b0, obs_seen}, 32'b1100010);
        chk("uart_state", {30'b0, state_seen}, 1);
        idle(); cycle();
        chk("uart_back_run", {30'b0, state_seen}, 0);
        chk("uart_stalls", stall_seen, base + 4);
        $display("uart wait done stalls=%0d", stall_seen - base);

        // FPU op with start held through release: two hold cycles, no restart; latency-1 instance never holds.
        ex_fpu_start = 1;
        cycle(); chk("fpu_hold0", {31'b0, obs_seen[2]}, 1); chk("fpu_b_nohold", {25'b0, obs_b_seen}, 32'b1100000);
        cycle(); chk("fpu_hold1", {31'b0, obs_seen[2]}, 1); chk("fpu_state", {30'b0, state_seen}, 2);
        cycle(); chk("fpu_release", {25'b0, obs_seen}, 32'b1100000);
        idle(); cycle(); chk("fpu_back_run", {30'b0, state_seen}, 0);

        // Reset during UART wait aborts it without an ack.
        ex_UARTtoReg = 1; cycle(); cycle();
        reset = 1; uart_rx_valid = 1; cycle(); chk("rst_wait_noack", {31'b0, obs_seen[1]}, 0);
        idle(); cycle();
        chk("rst_wait_state", {30'b0, state_seen}, 0);
        chk("rst_wait_noack2", {31'b0, obs_seen[1]}, 0);

        // Narrow counter instance saturates at all-ones.
        ex_MemRead = 1; ex_dst = 4; id_rs = 4;
        for (int i = 0; i < 10; i++) cycle();
        idle(); cycle();
        chk("stall_sat_b", stall_b_seen, 7);
        chk("stall_wide_a", stall_seen, 10);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            int u;
            idle();
            reset = ($urandom_range(0, 49) == 0);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_dst = 5'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom); ex_MemRead = 1'($urandom);
            u = $urandom_range(0, 5);
            ex_UARTtoReg = (u == 0); ex_RegtoUART = (u == 1);
            ex_fpu_start = ($urandom_range(0, 7) == 0);
            branch_taken = ($urandom_range(0, 3) == 0);
            uart_rx_valid = 1'($urandom); uart_tx_ready = 1'($urandom);
            cycle();
        end
        $display("random phase done cycles=%0d", cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
